// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
package debounce_pkg;
    localparam int SYNC_STAGES = 2;

    function automatic int hold_cnt_w(input int hold_ticks);
        return $clog2(hold_ticks + 1);
    endfunction
endpackage

// File: rtl/debounce_chan.sv
// One debounced button: synchroniser, sample window with hysteresis,
// edge pulses and a saturating long-press hold counter.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int WINDOW     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int HOLD_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic pb_in,
    output logic pb_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);
    localparam int                CW       = hold_cnt_w(HOLD_TICKS);
    localparam logic              INV      = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]     HOLD_MAX = CW'(HOLD_TICKS);
    localparam logic [CW-1:0]     HOLD_M1  = CW'(HOLD_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [WINDOW-1:0]      win_q;
    logic [CW-1:0]          hold_q;
    logic                   sample;
    logic                   level_d;

    // The flops carry pressed-polarity so their cleared value already means
    // "released"; a held button after reset then sees the full press latency.
    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = pb_level;
        if (&win_q)
            level_d = 1'b1;
        else if (~|win_q)
            level_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '0;
            win_q         <= '0;
            hold_q        <= '0;
            pb_level      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pb_in ^ INV};
            if (sample_en)
                win_q <= {win_q[WINDOW-2:0], sample};
            pb_level      <= level_d;
            press_pulse   <= level_d & ~pb_level;
            release_pulse <= ~level_d & pb_level;
            long_press    <= 1'b0;
            // Saturating count gives exactly one long_press per press.
            if (!pb_level) begin
                hold_q <= '0;
            end else if (sample_en && hold_q != HOLD_MAX) begin
                hold_q     <= hold_q + CW'(1);
                long_press <= (hold_q == HOLD_M1);
            end
        end
    end
endmodule

// File: rtl/debounce_multi.sv
// CHANNELS independent debounced push-buttons sharing one clock, reset and
// sample tick.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WINDOW     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int HOLD_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] pb_in,
    output logic [CHANNELS-1:0] pb_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .WINDOW     (WINDOW),
            .ACTIVE_LOW (ACTIVE_LOW),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .sample_en     (sample_en),
            .pb_in         (pb_in[g]),
            .pb_level      (pb_level[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_press    (long_press[g])
        );
    end
endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (active-low/long hold and
// active-high/short hold) checked against a sample-list model plus literals.
module tb_debounce_multi;
    localparam int CH     = 4;
    localparam int W      = 4;
    localparam int HOLD_A = 200;
    localparam int HOLD_B = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sen_a = 1'b1;
    logic          sen_b = 1'b0;
    logic [CH-1:0] pin_a = '1;
    logic [CH-1:0] pin_b = '0;
    logic [CH-1:0] lvl [2];
    logic [CH-1:0] prs [2];
    logic [CH-1:0] rel [2];
    logic [CH-1:0] lng [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sen_mode = 0;
    logic edge_sen_b = 1'b0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(CH), .WINDOW(W), .ACTIVE_LOW(1), .HOLD_TICKS(HOLD_A)) dut_a (
        .clk(clk), .rst(rst), .sample_en(sen_a), .pb_in(pin_a),
        .pb_level(lvl[0]), .press_pulse(prs[0]), .release_pulse(rel[0]), .long_press(lng[0]));

    debounce_multi #(.CHANNELS(CH), .WINDOW(W), .ACTIVE_LOW(0), .HOLD_TICKS(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .sample_en(sen_b), .pb_in(pin_b),
        .pb_level(lvl[1]), .press_pulse(prs[1]), .release_pulse(rel[1]), .long_press(lng[1]));

    // Model: last two pin samples, list of the last W samples, level and a
    // hold count per channel.
    bit          m_s0  [2][CH];
    bit          m_s1  [2][CH];
    bit          m_win [2][CH][W];
    int          m_cnt [2][CH];
    bit [CH-1:0] m_lvl [2];
    bit [CH-1:0] m_prs [2];
    bit [CH-1:0] m_rel [2];
    bit [CH-1:0] m_lng [2];
    int pcnt [2][CH];
    int rcnt [2][CH];
    int lcnt [2][CH];
    int hcnt [2][CH];

    logic          cap_sen_a, cap_sen_b;
    logic [CH-1:0] cap_pin_a, cap_pin_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lvl[d] = '0; m_prs[d] = '0; m_rel[d] = '0; m_lng[d] = '0;
            for (int c = 0; c < CH; c++) begin
                m_s0[d][c] = 0; m_s1[d][c] = 0; m_cnt[d][c] = 0;
                for (int k = 0; k < W; k++) m_win[d][c][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int d, input logic sen, input logic [CH-1:0] pressed, input int hold);
        for (int c = 0; c < CH; c++) begin
            int ones;
            bit nl;
            ones = 0;
            for (int k = 0; k < W; k++) ones += int'(m_win[d][c][k]);
            nl = (ones == W) ? 1'b1 : (ones == 0) ? 1'b0 : m_lvl[d][c];
            m_prs[d][c] = nl && !m_lvl[d][c];
            m_rel[d][c] = !nl && m_lvl[d][c];
            m_lng[d][c] = 1'b0;
            if (!m_lvl[d][c]) begin
                m_cnt[d][c] = 0;
            end else if (sen && m_cnt[d][c] < hold) begin
                m_cnt[d][c]++;
                m_lng[d][c] = (m_cnt[d][c] == hold);
            end
            if (sen) begin
                for (int k = W - 1; k > 0; k--) m_win[d][c][k] = m_win[d][c][k-1];
                m_win[d][c][0] = m_s1[d][c];
            end
            m_s1[d][c] = m_s0[d][c];
            m_s0[d][c] = pressed[c];
            m_lvl[d][c] = nl;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cap_sen_a = sen_a; cap_sen_b = sen_b;
        cap_pin_a = pin_a; cap_pin_b = pin_b;
    end

    // Compare process: advance the model for the edge just passed, then check.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            else begin
                model_step(0, cap_sen_a, ~cap_pin_a, HOLD_A);
                model_step(1, cap_sen_b, cap_pin_b, HOLD_B);
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_level_d%0d", d), lvl[d], m_lvl[d]);
                chk($sformatf("model_press_d%0d", d), prs[d], m_prs[d]);
                chk($sformatf("model_release_d%0d", d), rel[d], m_rel[d]);
                chk($sformatf("model_long_d%0d", d), lng[d], m_lng[d]);
                for (int c = 0; c < CH; c++) begin
                    if (prs[d][c] === 1'b1) pcnt[d][c]++;
                    if (rel[d][c] === 1'b1) rcnt[d][c]++;
                    if (lng[d][c] === 1'b1) lcnt[d][c]++;
                    if (lvl[d][c] === 1'b1) hcnt[d][c]++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
        edge_sen_b = sen_b;
        cyc++;
        case (sen_mode)
            0:       sen_b = (cyc % 4 == 0);
            1:       sen_b = 1'b0;
            default: sen_b = 1'b1;
        endcase
    endtask

    task automatic wait_lvl(input int d, input int c, input logic val, input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (lvl[d][c] === val) break;
        end
        chk(name, lvl[d][c], val);
    endtask

    initial begin
        int b0, b1, b2, ticks, fire;
        repeat (2) step();
        chk("reset_level_a", lvl[0], 0);
        chk("reset_press_a", prs[0], 0);
        chk("reset_level_b", lvl[1], 0);
        chk("reset_long_b", lng[1], 0);
        rst = 1'b0;
        repeat (8) step();

        // 1: clean press on ch0, level at the 7th edge after first sample
        pin_a[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) chk("t1_level_e6", lvl[0], 4'b0000);
            if (e == 7) begin
                chk("t1_level_e7", lvl[0], 4'b0001);
                chk("t1_press_e7", prs[0], 4'b0001);
            end
            if (e == 8) chk("t1_press_e8", prs[0], 4'b0000);
        end
        pin_a[0] = 1'b1;
        wait_lvl(0, 0, 1'b0, 20, "t1_release");

        // 2: 3-clk glitch, then press with per-clk bounce
        b0 = pcnt[0][1]; b1 = rcnt[0][1]; b2 = hcnt[0][1];
        pin_a[1] = 1'b0;
        repeat (3) step();
        pin_a[1] = 1'b1;
        repeat (12) step();
        chk("t2_glitch_level", hcnt[0][1] - b2, 0);
        chk("t2_glitch_press", pcnt[0][1] - b0, 0);
        chk("t2_glitch_release", rcnt[0][1] - b1, 0);
        pin_a[1] = 1'b0;
        wait_lvl(0, 1, 1'b1, 20, "t2_press");
        b0 = pcnt[0][1]; b1 = rcnt[0][1];
        for (int i = 0; i < 16; i++) begin
            pin_a[1] = ~pin_a[1];
            step();
        end
        chk("t2_bounce_level", lvl[0][1], 1'b1);
        chk("t2_bounce_press", pcnt[0][1] - b0, 0);
        chk("t2_bounce_release", rcnt[0][1] - b1, 0);
        pin_a[1] = 1'b1;
        wait_lvl(0, 1, 1'b0, 20, "t2_release");

        // 3: long press on dut_b with a tick every 4 clks
        pin_b[0] = 1'b1;
        wait_lvl(1, 0, 1'b1, 100, "t3_rise");
        chk("t3_press_pulse", prs[1][0], 1'b1);
        ticks = 0; fire = -1; b0 = lcnt[1][0];
        for (int i = 0; i < 60; i++) begin
            step();
            if (edge_sen_b) ticks++;
            if (lng[1][0] === 1'b1 && fire < 0) fire = ticks;
        end
        chk("t3_long_tick", fire, 5);
        chk("t3_long_once", lcnt[1][0] - b0, 1);
        pin_b[0] = 1'b0;
        wait_lvl(1, 0, 1'b0, 100, "t3_fall");
        pin_b[0] = 1'b1;
        wait_lvl(1, 0, 1'b1, 100, "t3_rise2");
        pin_b[0] = 1'b0;
        b0 = lcnt[1][0]; b1 = rcnt[1][0];
        wait_lvl(1, 0, 1'b0, 100, "t3_fall2");
        chk("t3_short_no_long", lcnt[1][0] - b0, 0);
        chk("t3_short_release", rcnt[1][0] - b1, 1);

        // 4: ch0 and ch3 together, then ch3 alone releases
        pin_a[0] = 1'b0; pin_a[3] = 1'b0;
        for (int i = 0; i < 20 && (lvl[0] & 4'b1001) == 4'b0000; i++) step();
        chk("t4_level_both", lvl[0], 4'b1001);
        chk("t4_press_both", prs[0], 4'b1001);
        pin_a[3] = 1'b1;
        wait_lvl(0, 3, 1'b0, 20, "t4_fall3");
        chk("t4_release_only3", rel[0], 4'b1000);
        chk("t4_level_only0", lvl[0], 4'b0001);

        // 5: asynchronous reset while ch0 is held
        #1 rst = 1'b1;
        #1;
        chk("t5_async_level", lvl[0], 0);
        chk("t5_async_press", prs[0], 0);
        step(); step();
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) chk("t5_level_e6", lvl[0], 4'b0000);
            if (e == 7) chk("t5_press_e7", prs[0], 4'b0001);
        end

        // 6: active-high pin with sample_en held low, then enabled
        sen_mode = 1; sen_b = 1'b0;
        pin_b[1] = 1'b1;
        b0 = hcnt[1][1];
        repeat (20) step();
        chk("t6_frozen", hcnt[1][1] - b0, 0);
        sen_mode = 2; sen_b = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) chk("t6_level_e4", lvl[1][1], 1'b0);
            if (e == 5) chk("t6_level_e5", lvl[1][1], 1'b1);
        end
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
